// File: rtl/mesh_acc_drain.sv
// Result-side drain for the systolic mesh: deskews the bottom-edge accumulator bus
// into aligned rows, queues them in a small FIFO and hands them out over valid/ready.
module mesh_acc_drain #(
  parameter int MESH_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             pump_i,
  input  logic                             first_i,
  input  logic [ROW_W-1:0]                 n_rows_i,
  input  logic [MESH_WIDTH*DATA_WIDTH-1:0] acc_i,
  output logic                             stall_o,
  output logic                             row_valid_o,
  input  logic                             row_ready_i,
  output logic [MESH_WIDTH*DATA_WIDTH-1:0] row_data_o,
  output logic [ROW_W-1:0]                 row_idx_o,
  output logic                             row_last_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [1:0]                       state_o
);
  localparam int M  = MESH_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int RW = M * DW;
  localparam int SW = (M > 1) ? $clog2(M) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] SK_FULL  = SW'(M - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, EMPTYING = 2'd2} state_t;

  state_t                state;
  logic [ROW_W-1:0]      n_rows;
  logic [ROW_W-1:0]      row_cnt;
  logic [SW-1:0]         sk;
  logic                  err;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [RW-1:0]         data_mem [FIFO_DEPTH];
  logic [ROW_W-1:0]      idx_mem  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic [RW-1:0]         aligned;

  logic                  pump_acc;
  logic                  first_ok;
  logic                  drain_pump;
  logic                  push;
  logic                  pop;
  logic                  is_last;
  logic [SW-1:0]         sk_cur;
  logic [ROW_W-1:0]      n_cur;
  logic [ROW_W-1:0]      r_cur;

  // Handshake: a row transfers in any cycle where row_valid_o and row_ready_i are
  // both high; the head entry is held unchanged until that happens.
  assign pump_acc   = pump_i & ~stall_o;
  assign first_ok   = pump_acc & first_i & (state == IDLE) & (n_rows_i != '0);
  assign drain_pump = pump_acc & ((state == DRAIN) | first_ok);
  // The first pump counts as k=0 / row 0, so use cleared views while still in IDLE.
  assign sk_cur     = (state == IDLE) ? '0 : sk;
  assign r_cur      = (state == IDLE) ? '0 : row_cnt;
  assign n_cur      = first_ok ? n_rows_i : n_rows;
  assign push       = drain_pump & (sk_cur == SK_FULL);
  assign is_last    = (r_cur == n_cur - 1'b1);
  assign pop        = row_valid_o & row_ready_i;

  // Column j lags column 0 by j pumps, so it is delayed by M-1-j pumps to line up.
  for (genvar j = 0; j < M; j++) begin : g_col
    if (j == M - 1) begin : g_direct
      assign aligned[j*DW +: DW] = acc_i[j*DW +: DW];
    end else begin : g_dly
      localparam int D = M - 1 - j;
      logic [DW-1:0] line [D];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < D; s++) line[s] <= '0;
        end else if (pump_acc) begin
          line[0] <= acc_i[j*DW +: DW];
          for (int s = 1; s < D; s++) line[s] <= line[s-1];
        end
      end
      assign aligned[j*DW +: DW] = line[D-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      n_rows  <= '0;
      row_cnt <= '0;
      sk      <= '0;
      err     <= 1'b0;
    end else begin
      if ((pump_i & stall_o & (state != EMPTYING)) |
          (pump_i & first_i & (state != IDLE)) |
          (pump_acc & first_i & (state == IDLE) & (n_rows_i == '0)))
        err <= 1'b1;
      if (first_ok) n_rows <= n_rows_i;
      if (drain_pump) sk <= (sk_cur == SK_FULL) ? sk_cur : sk_cur + 1'b1;
      if (push) row_cnt <= r_cur + 1'b1;
      else if (first_ok) row_cnt <= '0;
      case (state)
        IDLE:     if (first_ok) state <= (push & is_last) ? EMPTYING : DRAIN;
        DRAIN:    if (push & is_last) state <= EMPTYING;
        EMPTYING: if (pop & row_last_o) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    if (push & ~pop) count_next = count + 1'b1;
    else if (pop & ~push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stall_o  <= 1'b0;
      last_mem <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        idx_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= aligned;
        idx_mem[wr_ptr]  <= r_cur;
        last_mem[wr_ptr] <= is_last;
        wr_ptr           <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      count   <= count_next;
      stall_o <= (count_next == CNT_FULL);
    end
  end

  assign row_valid_o = (count != '0);
  assign row_data_o  = data_mem[rd_ptr];
  assign row_idx_o   = idx_mem[rd_ptr];
  assign row_last_o  = last_mem[rd_ptr];
  assign done_o      = pop & row_last_o & (state == EMPTYING);
  assign busy_o      = (state != IDLE);
  assign err_o       = err;
  assign state_o     = state;
endmodule

// File: tb/tb_mesh_acc_drain.sv
// Directed bench for mesh_acc_drain: basic drain, backpressure, pump gaps,
// protocol errors, reset mid-drain and a single-row drain.
module tb_mesh_acc_drain;
  localparam int M  = 4;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int RW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            pump;
  logic            first;
  logic [RW-1:0]   n_rows;
  logic [M*DW-1:0] acc;
  logic            stall;
  logic            row_valid;
  logic            ready;
  logic [M*DW-1:0] row_data;
  logic [RW-1:0]   row_idx;
  logic            row_last;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      state;

  int vectors = 0;
  int miscompares = 0;
  logic [RW-1:0] exp_q[$];

  mesh_acc_drain #(.MESH_WIDTH(M), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ROW_W(RW)) dut (
    .clk_i(clk), .rst_i(rst), .pump_i(pump), .first_i(first), .n_rows_i(n_rows),
    .acc_i(acc), .stall_o(stall), .row_valid_o(row_valid), .row_ready_i(ready),
    .row_data_o(row_data), .row_idx_o(row_idx), .row_last_o(row_last),
    .busy_o(busy), .done_o(done), .err_o(err), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [M*DW-1:0] obs, input logic [M*DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M*DW-1:0] exp_row(input int r);
    logic [M*DW-1:0] v;
    for (int j = 0; j < M; j++) v[j*DW +: DW] = DW'(100 * r + j);
    return v;
  endfunction

  // Column j carries row r on pump r+j; anything outside a real row is a marker.
  function automatic logic [M*DW-1:0] acc_for(input int k, input int n);
    logic [M*DW-1:0] v;
    int r;
    for (int j = 0; j < M; j++) begin
      r = k - j;
      if (r >= 0 && r < n) v[j*DW +: DW] = DW'(100 * r + j);
      else v[j*DW +: DW] = 32'hBAD0_0000 | DW'(j);
    end
    return v;
  endfunction

  task automatic drive_pump(input int k, input int n, input bit fst);
    pump   = 1'b1;
    first  = fst;
    n_rows = RW'(n);
    acc    = acc_for(k, n);
  endtask

  task automatic idle_in();
    pump  = 1'b0;
    first = 1'b0;
    acc   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_stall"}, stall, 0);
    chk({p, "_valid"}, row_valid, 0);
    chk({p, "_data"}, row_data, 0);
    chk({p, "_idx"}, row_idx, 0);
    chk({p, "_last"}, row_last, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, err, 0);
    chk({p, "_state"}, state, 0);
  endtask

  task automatic sb_tick(input int last_idx);
    logic [RW-1:0] e;
    if (row_valid && ready) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL sb_extra: observed row idx %0d expected no row", row_idx);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_idx", row_idx, e);
        chk("sb_data", row_data, exp_row(int'(e)));
        chk("sb_done", done, (int'(e) == last_idx));
      end
    end
    tick();
  endtask

  initial begin
    #100000;
    miscompares++;
    $display("FAIL timeout: observed no completion expected finish before 100us");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rst = 1'b1; ready = 1'b1; n_rows = '0;
    idle_in();
    tick(); tick();
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Basic drain, one pump per cycle, consumer always ready.
    for (int k = 0; k < 7; k++) begin
      drive_pump(k, 4, k == 0);
      tick();
      if (k == 0) chk("basic_busy_rise", busy, 1);
      if (k < 3) chk("basic_not_valid", row_valid, 0);
      else begin
        chk("basic_valid", row_valid, 1);
        chk("basic_data", row_data, exp_row(k - 3));
        chk("basic_idx", row_idx, k - 3);
        chk("basic_last", row_last, k == 6);
        chk("basic_done", done, k == 6);
        chk("basic_stall", stall, 0);
      end
    end
    idle_in();
    tick();
    chk("basic_end_valid", row_valid, 0);
    chk("basic_end_busy", busy, 0);
    chk("basic_end_done", done, 0);
    chk("basic_end_err", err, 0);

    // Pump gaps: pump every third cycle, random junk on acc between pumps.
    for (int k = 0; k < 7; k++) begin
      drive_pump(k, 4, k == 0);
      tick();
      if (k >= 3) begin
        chk("gap_valid", row_valid, 1);
        chk("gap_data", row_data, exp_row(k - 3));
        chk("gap_idx", row_idx, k - 3);
        chk("gap_done", done, k == 6);
      end
      idle_in();
      tick();
      chk("gap_popped", row_valid, 0);
      if (k == 6) chk("gap_busy_fall", busy, 0);
      tick();
    end
    chk("gap_err", err, 0);

    // Backpressure: FIFO fills on row 3 (pump 6), then a stalled pump is an error.
    ready = 1'b0;
    for (int r = 0; r < 8; r++) exp_q.push_back(RW'(r));
    for (int k = 0; k < 7; k++) begin
      drive_pump(k, 8, k == 0);
      tick();
      if (k == 5) begin
        chk("bp_stall_low", stall, 0);
        chk("bp_valid", row_valid, 1);
      end
    end
    chk("bp_stall_high", stall, 1);
    chk("bp_head_idx", row_idx, 0);
    drive_pump(7, 8, 0);
    tick();
    chk("bp_stall_err", err, 1);
    chk("bp_still_full", stall, 1);
    chk("bp_head_idx_kept", row_idx, 0);
    chk("bp_head_data_kept", row_data, exp_row(0));
    idle_in();
    ready = 1'b1;
    sb_tick(7);
    chk("bp_stall_fall", stall, 0);
    for (int k = 7; k < 11; k++) begin
      drive_pump(k, 8, 0);
      sb_tick(7);
    end
    idle_in();
    for (int i = 0; i < 20 && busy; i++) sb_tick(7);
    chk("bp_all_rows", exp_q.size(), 0);
    chk("bp_busy_fall", busy, 0);
    chk("bp_err_sticky", err, 1);

    // first_i while busy, then asynchronous reset mid-drain.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_pump(k, 4, k == 0);
      tick();
    end
    chk("mid_valid", row_valid, 1);
    chk("mid_err_clear", err, 0);
    drive_pump(5, 4, 1);
    n_rows = RW'(2);
    tick();
    chk("first_busy_err", err, 1);
    chk("first_busy_state", state, 1);
    chk("first_busy_head", row_idx, 0);
    idle_in();
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    tick();
    rst = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_pump(k, 2, k == 0);
      tick();
      if (k >= 3) begin
        chk("post_rst_valid", row_valid, 1);
        chk("post_rst_idx", row_idx, k - 3);
        chk("post_rst_data", row_data, exp_row(k - 3));
        chk("post_rst_last", row_last, k == 4);
        chk("post_rst_done", done, k == 4);
      end
    end
    idle_in();
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err, 0);

    // first_i with n_rows == 0 stays in IDLE and flags an error.
    drive_pump(0, 0, 1);
    tick();
    idle_in();
    chk("zero_rows_err", err, 1);
    chk("zero_rows_busy", busy, 0);
    chk("zero_rows_state", state, 0);

    // Single row; extra pumps while emptying are ignored without error.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_pump(k, 1, k == 0);
      tick();
    end
    chk("single_valid", row_valid, 1);
    chk("single_last", row_last, 1);
    chk("single_idx", row_idx, 0);
    chk("single_data", row_data, exp_row(0));
    chk("single_state", state, 2);
    drive_pump(4, 1, 0);
    tick();
    drive_pump(5, 1, 0);
    tick();
    idle_in();
    chk("single_pump_no_err", err, 0);
    chk("single_data_held", row_data, exp_row(0));
    chk("single_busy", busy, 1);
    ready = 1'b1;
    #1;
    chk("single_done", done, 1);
    tick();
    chk("single_busy_fall", busy, 0);
    chk("single_valid_fall", row_valid, 0);
    chk("single_done_pulse", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mesh_acc_drain.md
# mesh_acc_drain

Result-side drain for the systolic mesh. The mesh emits accumulator results skewed: column j carries a given row j pump steps after column 0. This block captures the bottom-edge `acc` bus on every pump and removes the skew with per-column delay lines. It pushes each complete, aligned row into a small FIFO and hands rows to the writeback path over a valid/ready handshake. It also provides stall feedback so the pump controller never overruns the FIFO.

## Interface
- `MESH_WIDTH`, 4: mesh columns (M); also the row width in elements.
- `DATA_WIDTH`, 32: element width.
- `FIFO_DEPTH`, 4: aligned-row FIFO entries, ≥2.
- `ROW_W`, 8: width of the row-count and row-index fields.
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `pump_i`  in  1  mesh advance strobe; `acc_i` is sampled only when this is high.
- `first_i`  in  1  qualifies the pump on which column 0 carries row 0; valid only together with `pump_i`.
- `n_rows_i`  in  ROW_W  number of result rows; captured on the `first_i` pump.
- `acc_i`  in  M×DATA_WIDTH  mesh bottom-edge accumulator outputs, indexed by column.
- `stall_o`  out  1  FIFO full; the controller must not pump while this is high.
- `row_valid_o`  out  1  an aligned row is available.
- `row_ready_i`  in  1  consumer accepts the row.
- `row_data_o`  out  M×DATA_WIDTH  aligned row; element j is column j.
- `row_idx_o`  out  ROW_W  row index, 0..n_rows-1.
- `row_last_o`  out  1  the row is index n_rows-1.
- `busy_o`  out  1  a drain is in progress.
- `done_o`  out  1  one-cycle pulse when the last row is handshaked.
- `err_o`  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- FSM states: IDLE, DRAIN, EMPTYING.
- IDLE → DRAIN on an accepted `first_i & pump_i`:
  - latch n_rows;
  - clear pump counter k to 0 (this pump is k=0);
  - clear the row index.
- Skew removal:
  - Column j passes through a delay of M-1-j pump-enabled registers. Column M-1 is direct.
  - All delay registers shift only on an accepted pump.
  - At accepted pump k with k ≥ M-1, the aligned row r = k-(M-1) is pushed into the FIFO if r < n_rows.
  - k increments on every accepted pump.
- DRAIN → EMPTYING on the pump that pushes row n_rows-1. Pumps in EMPTYING are ignored and do not count as errors.
- EMPTYING → IDLE on the handshake of row n_rows-1. `done_o` pulses in that cycle.
- An accepted pump is `pump_i & !stall_o`. A pump while `stall_o` is high sets `err_o`, shifts nothing and pushes nothing.
- `first_i` outside IDLE sets `err_o` and is ignored. `first_i` with `n_rows_i == 0` sets `err_o` and stays in IDLE.
- FIFO:
  - push on row completion; pop on `row_valid_o & row_ready_i`;
  - simultaneous push and pop leaves the count unchanged;
  - pointers wrap modulo FIFO_DEPTH;
  - the FIFO stores data, index and last.
- `stall_o` = (count == FIFO_DEPTH). It is registered from count, with no combinational path from `row_ready_i`.
- `row_valid_o` = count ≠ 0. Outputs are driven from the FIFO head; data is held stable while valid is high and ready is low.
- `busy_o` is high in DRAIN and EMPTYING.

## Timing
- Reset values: `stall_o`=0, `row_valid_o`=0, `row_data_o`=0, `row_idx_o`=0, `row_last_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0. Reset also clears the FIFO, the delay lines, k and the FSM (state = IDLE).
- Reset takes effect immediately, including mid-drain. A partial drain is discarded.
- Row r is written at the clock edge of accepted pump k = r+M-1. `row_valid_o` rises in the next cycle, so latency is M-1 accepted pumps plus 1 clock.
- With one pump per cycle and `row_ready_i`=1, rows emerge one per cycle and the FIFO never exceeds 1 entry.
- `stall_o` rises the cycle after the push that fills the FIFO, and falls the cycle after a pop from full.
- `busy_o` rises the cycle after `first_i`. It falls the cycle after `done_o`.

## Test plan
- **Basic drain.** M=4, n_rows=4, pump every cycle from `first_i`, ready=1, column j driving 100·r+j for row r with skew applied. Required: rows 0..3 valid in the cycles after pumps 3..6; row_data = {100r+3, 100r+2, 100r+1, 100r}; `row_last_o` on idx 3; `done_o` one cycle.
- **Backpressure.** n_rows=8, FIFO_DEPTH=4, ready=0. Required: `stall_o`=1 after the push of row 3 (pump 6); the controller holds pump. Raising ready drains rows in order 0..7 with no loss or duplicates.
- **Pump gaps.** Same as the basic drain, with pump high every third cycle. Required: identical row contents; each row valid one cycle after its completing pump.
- **Protocol errors.** Pump while `stall_o`=1 → `err_o`=1, FIFO contents unchanged. `first_i` while busy → ignored, `err_o`=1. `first_i` with n_rows=0 → stays IDLE, `err_o`=1.
- **Reset mid-drain.** Assert reset after row 1 is pushed. Required: all outputs return to their reset values immediately. A new `first_i` with n_rows=2 then drains correctly.
- **Single row.** n_rows=1. Required: row 0 valid after pump 3 with `row_last_o`=1, `done_o` on its handshake, and later pumps ignored without setting `err_o`.
